// File: rtl/top_level_pkg.sv
// Shared definitions for the nibble-entry calculator.
//   state_t      : entry FSM encoding (ENTER_A=0, ENTER_B=1, SHOW=2)
//   OP_*         : ALU opcodes carried on the MS switches
//   seg7_code()  : hex digit -> active-low 7-seg code {dp,g,f,e,d,c,b,a}, dp always off
package top_level_pkg;

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    SHOW    = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  function automatic logic [7:0] seg7_code(input logic [3:0] d);
    case (d)
      4'h0: seg7_code = 8'hC0;
      4'h1: seg7_code = 8'hF9;
      4'h2: seg7_code = 8'hA4;
      4'h3: seg7_code = 8'hB0;
      4'h4: seg7_code = 8'h99;
      4'h5: seg7_code = 8'h92;
      4'h6: seg7_code = 8'h82;
      4'h7: seg7_code = 8'hF8;
      4'h8: seg7_code = 8'h80;
      4'h9: seg7_code = 8'h90;
      4'hA: seg7_code = 8'h88;
      4'hB: seg7_code = 8'h83;
      4'hC: seg7_code = 8'hC6;
      4'hD: seg7_code = 8'hA1;
      4'hE: seg7_code = 8'h86;
      default: seg7_code = 8'h8E;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Hex digit to 7-segment pattern (active-low, dp off).
//   digit in  4  hex value
//   seg   out 8  {dp,g,f,e,d,c,b,a}
module seg7_decoder
  import top_level_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] seg
);

  assign seg = seg7_code(digit);

endmodule

// File: rtl/top_level.sv
// Nibble-entry calculator top. Two 4-bit operands are keyed on Din and
// confirmed with the active-low next button; the 16-bit result of the
// MS-selected operation is shown on four 7-seg digits.
//   clk, clear(async, active-low)  clock / reset
//   next        step button, active-low, asynchronous to clk
//   MS, Din     opcode / operand switches
//   level       chain select, used on the press that leaves SHOW
//   EDL1..3     combinational echoes of Din, level, MS
//   EDL4        flag of last executed operation
//   Done_out    high while showing a result
//   LED0..3     7-seg of result nibbles (LED0 = bits 3:0)
//   HEX4        7-seg of MS
module top_level
  import top_level_pkg::*;
(
  input  logic       clk,
  input  logic       clear,
  input  logic       next,
  input  logic [2:0] MS,
  input  logic [3:0] Din,
  input  logic       level,
  output logic [3:0] EDL1,
  output logic       EDL2,
  output logic [2:0] EDL3,
  output logic       EDL4,
  output logic       Done_out,
  output logic [7:0] LED0,
  output logic [7:0] LED1,
  output logic [7:0] LED2,
  output logic [7:0] LED3,
  output logic [7:0] HEX4
);

  localparam int NUM_DIGITS = 4;

  state_t      state, state_n;
  logic [15:0] a, b, r;
  logic        sync1, sync2, sync_q;
  logic        press;
  logic        ld_a, ld_b, chain;
  logic [15:0] op_b, alu_res;
  logic        alu_flag;
  logic [16:0] sum;
  logic [31:0] prod, shl_w, shr_w;

  // Button synchronizer plus edge history; all idle at 1 (released) so a
  // button already held at reset release does not count as a press.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      sync1  <= next;
      sync2  <= sync1;
      sync_q <= sync2;
    end
  end

  assign press = sync_q & ~sync2;

  always_comb begin
    state_n = state;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    chain   = 1'b0;
    if (press) begin
      case (state)
        ENTER_A: begin state_n = ENTER_B; ld_a = 1'b1; end
        ENTER_B: begin state_n = SHOW;    ld_b = 1'b1; end
        SHOW: begin
          if (level) begin state_n = ENTER_B; chain = 1'b1; end
          else       state_n = ENTER_A;
        end
        default: state_n = ENTER_A;
      endcase
    end
  end

  // The result is computed in the same clock B is captured, so the ALU
  // sees the switch value directly on that press.
  assign op_b = ld_b ? {12'b0, Din} : b;

  always_comb begin
    sum      = {1'b0, a} + {1'b0, op_b};
    prod     = 32'(a) * 32'(op_b);
    // Widened shifts: the bits pushed out land in the spare half.
    shl_w    = {16'b0, a} << op_b[3:0];
    shr_w    = {a, 16'b0} >> op_b[3:0];
    alu_res  = '0;
    alu_flag = 1'b0;
    case (MS)
      OP_ADD: begin alu_res = sum[15:0];   alu_flag = sum[16];       end
      OP_SUB: begin alu_res = a - op_b;    alu_flag = (a < op_b);    end
      OP_MUL: begin alu_res = prod[15:0];  alu_flag = |prod[31:16];  end
      OP_AND: alu_res = a & op_b;
      OP_OR:  alu_res = a | op_b;
      OP_XOR: alu_res = a ^ op_b;
      OP_SHL: begin alu_res = shl_w[15:0];  alu_flag = |shl_w[31:16]; end
      default: begin alu_res = shr_w[31:16]; alu_flag = |shr_w[15:0]; end
    endcase
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state <= ENTER_A;
      a     <= '0;
      b     <= '0;
      r     <= '0;
      EDL4  <= 1'b0;
    end else begin
      state <= state_n;
      if (ld_a)  a <= {12'b0, Din};
      if (chain) a <= r;
      if (ld_b) begin
        b    <= op_b;
        r    <= alu_res;
        EDL4 <= alu_flag;
      end
    end
  end

  assign Done_out = (state == SHOW);
  assign EDL1     = Din;
  assign EDL2     = level;
  assign EDL3     = MS;

  logic [NUM_DIGITS-1:0][7:0] led_seg;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_led
    seg7_decoder u_dec (
      .digit (r[4*i +: 4]),
      .seg   (led_seg[i])
    );
  end

  seg7_decoder u_hex4 (
    .digit ({1'b0, MS}),
    .seg   (HEX4)
  );

  assign LED0 = led_seg[0];
  assign LED1 = led_seg[1];
  assign LED2 = led_seg[2];
  assign LED3 = led_seg[3];

endmodule

// File: tb/tb_top_level.sv
module tb_top_level;

  logic       clk = 1'b0;
  logic       clear, next, level;
  logic [2:0] MS;
  logic [3:0] Din;
  logic [3:0] EDL1;
  logic       EDL2, EDL4, Done_out;
  logic [2:0] EDL3;
  logic [7:0] LED0, LED1, LED2, LED3, HEX4;

  top_level dut (
    .clk(clk), .clear(clear), .next(next), .MS(MS), .Din(Din), .level(level),
    .EDL1(EDL1), .EDL2(EDL2), .EDL3(EDL3), .EDL4(EDL4), .Done_out(Done_out),
    .LED0(LED0), .LED1(LED1), .LED2(LED2), .LED3(LED3), .HEX4(HEX4)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference: display table and behaviour from the board description.
  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
  int unsigned m_a, m_b, m_r;
  bit          m_flag;
  int          m_st;   // 0 = entering A, 1 = entering B, 2 = showing

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_r = 0; m_flag = 0; m_st = 0;
  endtask

  task automatic model_alu(input int unsigned a, input int unsigned b, input int op);
    longint p;
    int     s;
    s = b % 16;
    case (op)
      0: begin m_r = (a + b) % 65536; m_flag = (a + b) > 65535; end
      1: begin m_r = (a - b) & 32'hFFFF; m_flag = (a < b); end
      2: begin p = longint'(a) * b; m_r = int'(p % 65536); m_flag = p > 65535; end
      3: begin m_r = a & b; m_flag = 0; end
      4: begin m_r = a | b; m_flag = 0; end
      5: begin m_r = a ^ b; m_flag = 0; end
      6: begin p = longint'(a) * (longint'(1) << s);
               m_r = int'(p % 65536); m_flag = p > 65535; end
      default: begin m_r = a / (1 << s); m_flag = (a % (1 << s)) != 0; end
    endcase
  endtask

  task automatic model_press();
    case (m_st)
      0: begin m_a = Din; m_st = 1; end
      1: begin m_b = Din; model_alu(m_a, m_b, int'(MS)); m_st = 2; end
      default: begin
        if (level) begin m_a = m_r; m_st = 1; end
        else m_st = 0;
      end
    endcase
  endtask

  // Hold the button for 'hold' clocks, release, let the action settle.
  task automatic press(input int hold);
    @(posedge clk); #1 next = 1'b0;
    repeat (hold) @(posedge clk);
    #1 next = 1'b1;
    repeat (4) @(posedge clk);
    model_press();
  endtask

  task automatic check_all(input string tag);
    logic [15:0] r16;
    @(negedge clk);
    r16 = m_r[15:0];
    chk({tag, ".LED0"}, LED0, seg_tbl[r16[3:0]]);
    chk({tag, ".LED1"}, LED1, seg_tbl[r16[7:4]]);
    chk({tag, ".LED2"}, LED2, seg_tbl[r16[11:8]]);
    chk({tag, ".LED3"}, LED3, seg_tbl[r16[15:12]]);
    chk({tag, ".done"}, Done_out, (m_st == 2));
    chk({tag, ".EDL4"}, EDL4, m_flag);
    chk({tag, ".HEX4"}, HEX4, seg_tbl[{1'b0, MS}]);
    chk({tag, ".EDL1"}, EDL1, Din);
    chk({tag, ".EDL2"}, EDL2, level);
    chk({tag, ".EDL3"}, EDL3, MS);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [3:0] av, input logic [3:0] bv);
    Din = av; press(3);
    MS = op; Din = bv; press(3);
  endtask

  initial begin
    clear = 1'b0; next = 1'b1; level = 1'b0; MS = 3'd0; Din = 4'd0;
    model_reset();
    repeat (3) @(posedge clk);
    check_all("reset");
    #3 clear = 1'b1;
    repeat (2) @(posedge clk);

    run_op(3'd0, 4'd2, 4'd4);
    check_all("add_2_4");
    chk("add_2_4.R", LED0, 8'h82);

    level = 1'b0; press(2);
    run_op(3'd1, 4'd3, 4'd5);
    check_all("sub_3_5");
    chk("sub_3_5.R", {LED3, LED0}, 16'h8E86);

    press(2);
    run_op(3'd2, 4'hF, 4'hF);
    check_all("mul_F_F");
    chk("mul_F_F.R", {LED1, LED0}, 16'h86F9);

    press(2);
    run_op(3'd0, 4'd2, 4'd4);
    level = 1'b1; press(2);
    check_all("chain_enter");
    MS = 3'd2; Din = 4'd4; press(2);
    check_all("chain_mul");
    chk("chain_mul.LED1", LED1, 8'hF9);

    // Long hold: exactly one step each time.
    level = 1'b0; press(2);
    Din = 4'd7; press(20);
    check_all("hold_a");
    MS = 3'd4; Din = 4'd8; press(20);
    check_all("hold_b");

    // Reset while entering B discards the entry.
    press(2);
    Din = 4'd9; press(2);
    check_all("pre_clear");
    @(negedge clk); #2 clear = 1'b0;
    model_reset();
    MS = 3'd5; Din = 4'hA;
    check_all("in_clear");
    @(posedge clk); #3 clear = 1'b1;
    repeat (2) @(posedge clk);
    run_op(3'd0, 4'd1, 4'd1);
    check_all("post_clear");

    // Random sequences, including boundary shift amounts and chaining.
    for (int i = 0; i < 60; i++) begin
      Din   = 4'($urandom_range(0, 15));
      MS    = 3'($urandom_range(0, 7));
      level = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk); #2 clear = 1'b0;
        model_reset();
        check_all("rnd_clear");
        @(posedge clk); #3 clear = 1'b1;
        repeat (2) @(posedge clk);
      end else begin
        press($urandom_range(1, 6));
        check_all("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
